// File: rtl/fft_pair_feeder_pkg.sv
// -----------------------------------------------------------------------------
// fft_pair_feeder_pkg
// Shared types and constants for the DIF FFT input stage and its neighbours.
//   complex_fp_t : one complex sample, each field a sign bit plus I_DATA bits
//   FP_*         : commonly used single-precision bit patterns
// -----------------------------------------------------------------------------
package fft_pair_feeder_pkg;

  localparam int I_EXP  = 8;
  localparam int I_MNT  = 23;
  localparam int I_DATA = I_EXP + I_MNT;

  typedef struct packed {
    logic [I_DATA:0] r;
    logic [I_DATA:0] i;
  } complex_fp_t;

  localparam logic [I_DATA:0] FP_ONE     = 32'h3f80_0000;
  localparam logic [I_DATA:0] FP_NEG_ONE = 32'hbf80_0000;
  localparam logic [I_DATA:0] FP_ZERO    = 32'h0000_0000;

endpackage

// File: rtl/fft_pair_feeder_if.sv
// -----------------------------------------------------------------------------
// fft_pair_feeder_if
// Sample stream into the pair feeder and butterfly operand bus out of it.
//   in_valid / in_sof / in_data : natural-order input samples
//   A / B / out_k / out_valid   : butterfly operands, twiddle index, enable
//   sync_err                    : one-cycle pulse when a frame is resynced
// Modports:
//   master : upstream side (drives samples, observes operands)
//   slave  : the feeder itself
// -----------------------------------------------------------------------------
interface fft_pair_feeder_if
  import fft_pair_feeder_pkg::*;
#(
  parameter int HALF = 4
);
  localparam int CNT_W = $clog2(2 * HALF);

  logic              in_valid;
  logic              in_sof;
  complex_fp_t       in_data;
  complex_fp_t       A;
  complex_fp_t       B;
  logic [CNT_W-2:0]  out_k;
  logic              out_valid;
  logic              sync_err;

  modport master (
    output in_valid, in_sof, in_data,
    input  A, B, out_k, out_valid, sync_err
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output A, B, out_k, out_valid, sync_err
  );

endinterface

// File: rtl/fp_sample_buf.sv
// -----------------------------------------------------------------------------
// fp_sample_buf
// DEPTH-entry register array of complex samples, one write port with a
// synchronous write and one combinationally read port. Contents are not reset.
//   clk     : clock, rising edge
//   wr_en   : write wr_data to wr_addr on this edge
//   wr_addr : write address
//   wr_data : sample to store
//   rd_addr : read address
//   rd_data : sample at rd_addr (combinational)
// -----------------------------------------------------------------------------
module fp_sample_buf
  import fft_pair_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  complex_fp_t   wr_data,
  input  logic [AW-1:0] rd_addr,
  output complex_fp_t   rd_data
);

  complex_fp_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_pair_feeder.sv
// -----------------------------------------------------------------------------
// fft_pair_feeder
// Input stage for the floating-point radix-2 DIF butterfly. Stores the first
// half of each frame and, as each second-half sample k+HALF arrives, emits the
// pair (sample k, sample k+HALF) with the twiddle index k one cycle later.
//   clk   : clock, rising edge
//   reset : asynchronous reset, active-low
//   bus   : slave side of fft_pair_feeder_if (samples in, operands out)
// -----------------------------------------------------------------------------
module fft_pair_feeder
  import fft_pair_feeder_pkg::*;
#(
  parameter int HALF = 4
) (
  input  logic             clk,
  input  logic             reset,
  fft_pair_feeder_if.slave bus
);

  localparam int CNT_W = $clog2(2 * HALF);
  localparam int AW    = CNT_W - 1;

  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] base_p0;
  logic             resync_p0;
  logic             fill_p0;
  logic             pair_p0;
  logic [AW-1:0]    addr_p0;
  complex_fp_t      held_p0;

  complex_fp_t      a_p1;
  complex_fp_t      b_p1;
  logic [AW-1:0]    k_p1;
  logic             vld_p1;
  logic             err_p1;

  // Stage p0: classify the incoming sample. An in_sof forces the sample to
  // position 0 whatever the counter says, which both starts a normal frame
  // and abandons a partial one. Since HALF is a power of two, pos-HALF in the
  // second half is just the low bits of pos, so the same address serves as
  // the fill write address and the pair read address / twiddle index.
  always_comb begin
    base_p0   = bus.in_sof ? '0 : pos;
    resync_p0 = bus.in_valid && bus.in_sof && (pos != '0);
    fill_p0   = bus.in_valid && !base_p0[CNT_W-1];
    pair_p0   = bus.in_valid &&  base_p0[CNT_W-1];
    addr_p0   = base_p0[AW-1:0];
  end

  fp_sample_buf #(
    .DEPTH (HALF),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (fill_p0),
    .wr_addr (addr_p0),
    .wr_data (bus.in_data),
    .rd_addr (addr_p0),
    .rd_data (held_p0)
  );

  // Frame position; the increment wraps 2*HALF-1 -> 0 on its own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos <= '0;
    end else if (bus.in_valid) begin
      pos <= base_p0 + CNT_W'(1);
    end
  end

  // Stage p1: registered butterfly operands. Operands and index hold while
  // no pair is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      k_p1   <= '0;
    end else begin
      vld_p1 <= pair_p0;
      err_p1 <= resync_p0;
      if (pair_p0) begin
        a_p1 <= held_p0;
        b_p1 <= bus.in_data;
        k_p1 <= addr_p0;
      end
    end
  end

  assign bus.A         = a_p1;
  assign bus.B         = b_p1;
  assign bus.out_k     = k_p1;
  assign bus.out_valid = vld_p1;
  assign bus.sync_err  = err_p1;

endmodule

// File: tb/tb_fft_pair_feeder.sv
// -----------------------------------------------------------------------------
// tb_fft_pair_feeder
// Bench for fft_pair_feeder with HALF=4. Outputs are compared every cycle
// against a frame-list reference model, with table-driven and hand-written
// checks for the named scenarios.
// -----------------------------------------------------------------------------
module tb_fft_pair_feeder;
  import fft_pair_feeder_pkg::*;

  localparam int HALF = 4;

  typedef struct {
    logic [31:0] r;
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  k;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] fp_tab [17];
  vec_t        tbl [8];

  logic [63:0] mq [$];
  logic        m_vld;
  logic        m_err;
  logic [63:0] m_a;
  logic [63:0] m_b;
  logic [1:0]  m_k;

  fft_pair_feeder_if #(.HALF(HALF)) bus ();

  fft_pair_feeder #(.HALF(HALF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] cx(input logic [31:0] r);
    return {r, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_vld = 1'b0;
    m_err = 1'b0;
    m_a   = '0;
    m_b   = '0;
    m_k   = '0;
  endtask

  // Frame kept as a list of accepted samples; a pair is due once the list
  // grows past HALF entries.
  task automatic model_step();
    int n;
    m_vld = 1'b0;
    m_err = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_sof && mq.size() != 0) begin
        m_err = 1'b1;
        mq.delete();
      end
      mq.push_back(bus.in_data);
      n = mq.size();
      if (n > HALF) begin
        m_vld = 1'b1;
        m_a   = mq[n - 1 - HALF];
        m_b   = bus.in_data;
        m_k   = 2'(n - 1 - HALF);
        if (n == 2 * HALF) mq.delete();
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
    chk("sync_err",  64'(bus.sync_err),  64'(m_err));
    chk("A",         bus.A,              m_a);
    chk("B",         bus.B,              m_b);
    chk("out_k",     64'(bus.out_k),     64'(m_k));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at
  // the next falling edge.
  task automatic cycle(input logic v, input logic s, input logic [31:0] r);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = complex_fp_t'(cx(r));
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic prev;
    checks = 0;
    errors = 0;
    fp_tab[0]  = 32'h0000_0000;
    fp_tab[1]  = 32'h3F80_0000; fp_tab[2]  = 32'h4000_0000;
    fp_tab[3]  = 32'h4040_0000; fp_tab[4]  = 32'h4080_0000;
    fp_tab[5]  = 32'h40A0_0000; fp_tab[6]  = 32'h40C0_0000;
    fp_tab[7]  = 32'h40E0_0000; fp_tab[8]  = 32'h4100_0000;
    fp_tab[9]  = 32'h4110_0000; fp_tab[10] = 32'h4120_0000;
    fp_tab[11] = 32'h4130_0000; fp_tab[12] = 32'h4140_0000;
    fp_tab[13] = 32'h4150_0000; fp_tab[14] = 32'h4160_0000;
    fp_tab[15] = 32'h4170_0000; fp_tab[16] = 32'h4180_0000;

    tbl[0] = '{32'h3F80_0000, 1'b0, 32'h0,         32'h0,         2'd0};
    tbl[1] = '{32'h4000_0000, 1'b0, 32'h0,         32'h0,         2'd0};
    tbl[2] = '{32'h4040_0000, 1'b0, 32'h0,         32'h0,         2'd0};
    tbl[3] = '{32'h4080_0000, 1'b0, 32'h0,         32'h0,         2'd0};
    tbl[4] = '{32'h40A0_0000, 1'b1, 32'h3F80_0000, 32'h40A0_0000, 2'd0};
    tbl[5] = '{32'h40C0_0000, 1'b1, 32'h4000_0000, 32'h40C0_0000, 2'd1};
    tbl[6] = '{32'h40E0_0000, 1'b1, 32'h4040_0000, 32'h40E0_0000, 2'd2};
    tbl[7] = '{32'h4100_0000, 1'b1, 32'h4080_0000, 32'h4100_0000, 2'd3};

    model_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    reset        = 1'b0;
    @(negedge clk);

    // Reset held with in_valid toggling, then one idle cycle after release.
    for (int i = 0; i < 6; i++) cycle(1'(i % 2), 1'(i == 1), $urandom);
    chk("rst_A", bus.A, 64'h0);
    reset = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    chk("post_rst_vld", 64'(bus.out_valid), 64'h0);

    // Continuous frame from the table.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'(i == 0), tbl[i].r);
      chk("tbl_vld", 64'(bus.out_valid), 64'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk("tbl_A", 64'(bus.A.r), 64'(tbl[i].a));
        chk("tbl_B", 64'(bus.B.r), 64'(tbl[i].b));
        chk("tbl_k", 64'(bus.out_k), 64'(tbl[i].k));
      end
    end
    cycle(1'b0, 1'b0, 32'h0);

    // Gapped frame: valid every other cycle, never two pairs in a row.
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) cycle(1'b1, 1'(i == 0), fp_tab[i / 2 + 1]);
      else            cycle(1'b0, 1'b0, $urandom);
      chk("gap_no_b2b", 64'(prev & bus.out_valid), 64'h0);
      prev = bus.out_valid;
    end

    // Back-to-back frames, 1..8 then 9..16 with no idle cycle.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'(i % 8 == 0), fp_tab[i + 1]);
      if (i == 7 || i == 12) chk("b2b_vld", 64'(bus.out_valid), 64'h1);
      if (i == 12) chk("b2b_pair", {bus.A.r, bus.B.r}, {32'h4110_0000, 32'h4150_0000});
    end
    cycle(1'b0, 1'b0, 32'h0);

    // Resync after 3 samples.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'(i == 0), fp_tab[i + 1]);
    cycle(1'b1, 1'b1, fp_tab[9]);
    chk("resync_err", 64'(bus.sync_err), 64'h1);
    chk("resync_novld", 64'(bus.out_valid), 64'h0);
    for (int i = 10; i <= 16; i++) begin
      cycle(1'b1, 1'b0, fp_tab[i]);
      if (i <= 12) chk("resync_quiet", 64'(bus.out_valid), 64'h0);
      if (i == 13) chk("resync_p0", {bus.A.r, bus.B.r, 30'(bus.out_k)},
                       {32'h4110_0000, 32'h4150_0000, 30'd0});
      if (i == 16) chk("resync_p3", {bus.A.r, bus.B.r, 30'(bus.out_k)},
                       {32'h4140_0000, 32'h4180_0000, 30'd3});
    end

    // Random traffic with occasional resyncs.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), $urandom);
    end
    cycle(1'b0, 1'b0, 32'h0);

    // Async reset mid-frame between samples 5 and 6.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'(i == 0), fp_tab[i + 1]);
    chk("pre_rst_vld", 64'(bus.out_valid), 64'h1);
    #1 reset = 1'b0;
    #1;
    chk("async_vld", 64'(bus.out_valid), 64'h0);
    chk("async_A", bus.A, 64'h0);
    model_reset();
    cycle(1'b1, 1'b0, fp_tab[6]);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, fp_tab[i + 9]);
      if (i == 4) chk("fresh_p0", {bus.A.r, bus.B.r, 30'(bus.out_k)},
                      {32'h4110_0000, 32'h4150_0000, 30'd0});
    end
    cycle(1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
